// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between NREQ writeback
//   sources (ALU, LSU load return, CSR/MUL-DIV, ...). A round-robin search
//   picks one valid source per cycle and accepts it through a valid/ready
//   handshake. The winning write is registered, so the register file sees a
//   clean write pulse one cycle after acceptance.
//
// Parameters:
//   NREQ          number of writeback sources, legal range 2..4
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   req_valid_i    per-source write request valid            [NREQ]
//   req_idx_i      per-source destination index, source i at [5i+4:5i]
//   req_wdata_i    per-source write data, source i at slice i [NREQ*XLEN]
//   req_ready_o    per-source accept, one-hot or zero (combinational)
//   stall_i        blocks all acceptance this cycle
//   rd_en_o        register-file write enable (never set for x0)
//   rd_idx_o       register-file write index
//   rd_wdata_o     register-file write data
//   gnt_id_o       source number of the write currently on rd_*
//
// Optional feature (macro RF_WB_PERF_EN):
//   conflict_cnt_o saturating count of unstalled cycles with two or more
//                  requests valid
//   stall_cnt_o    saturating count of stalled cycles with any request valid
//
// XLEN normally comes from defines.v; a 32-bit fallback is provided so the
// block also builds stand-alone.
// ---------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif

module rf_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*5-1:0]      req_idx_i,
  input  logic [NREQ*`XLEN-1:0]  req_wdata_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic                   stall_i,
  output logic                   rd_en_o,
  output logic [4:0]             rd_idx_o,
  output logic [`XLEN-1:0]       rd_wdata_o,
  output logic [1:0]             gnt_id_o
`ifdef RF_WB_PERF_EN
  ,
  output logic [31:0]            conflict_cnt_o,
  output logic [31:0]            stall_cnt_o
`endif
);

  // Source numbers are at most 3, so a 2-bit id suffices; sums of an id and
  // an offset are formed in 3 bits before wrapping back into range.
  localparam logic [2:0] NREQ_W = 3'(NREQ);

  // Wrap a 3-bit sum (at most 6) back into 0..NREQ-1. One subtraction is
  // enough because both operands are already below NREQ.
  function automatic logic [1:0] wrapId(input logic [2:0] v);
    if (v >= NREQ_W) begin
      wrapId = 2'(v - NREQ_W);
    end else begin
      wrapId = v[1:0];
    end
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]        rr_ptr_q,   rr_ptr_d;
  logic              rd_en_q,    rd_en_d;
  logic [4:0]        rd_idx_q,   rd_idx_d;
  logic [`XLEN-1:0]  rd_wdata_q, rd_wdata_d;
  logic [1:0]        gnt_id_q,   gnt_id_d;

  // -------------------------------------------------------------------------
  // Round-robin search
  // -------------------------------------------------------------------------
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] cand;
  logic       cand_valid;

  // Walk the sources starting at rr_ptr and take the first valid one. The
  // candidate's valid bit is picked by comparing against every constant
  // source number so that no index ever has to be narrower than the id.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    cand       = '0;
    cand_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand       = wrapId({1'b0, rr_ptr_q} + 3'(k));
      cand_valid = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if (cand == 2'(j)) begin
          cand_valid = req_valid_i[j];
        end
      end
      if (!win_found && cand_valid) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // A winner only becomes a transfer when nothing blocks acceptance. Ready
  // is asserted only for a valid winner, so ready alone marks a transfer.
  logic xfer;
  assign xfer = win_found && !stall_i && !reset;

  always_comb begin
    req_ready_o = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready_o[j] = xfer && (win_id == 2'(j));
    end
  end

  // -------------------------------------------------------------------------
  // Winner payload select
  // -------------------------------------------------------------------------
  logic [4:0]       sel_idx;
  logic [`XLEN-1:0] sel_wdata;

  always_comb begin
    sel_idx   = '0;
    sel_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_id == 2'(j)) begin
        sel_idx   = req_idx_i[j*5 +: 5];
        sel_wdata = req_wdata_i[j*`XLEN +: `XLEN];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage and pointer next state
  // -------------------------------------------------------------------------
  // A write to x0 is still consumed from its source but never raises the
  // enable. Without a transfer the enable drops and the payload and grant id
  // keep showing the last accepted write.
  always_comb begin
    rd_en_d    = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_wdata_d = rd_wdata_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      rd_en_d    = (sel_idx != 5'd0);
      rd_idx_d   = sel_idx;
      rd_wdata_d = sel_wdata;
      gnt_id_d   = win_id;
      rr_ptr_d   = wrapId({1'b0, win_id} + 3'd1);
    end
  end

  // Reset throws away any write sitting in the output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_wdata_q <= '0;
      gnt_id_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_en_q    <= rd_en_d;
      rd_idx_q   <= rd_idx_d;
      rd_wdata_q <= rd_wdata_d;
      gnt_id_q   <= gnt_id_d;
    end
  end

  assign rd_en_o    = rd_en_q;
  assign rd_idx_o   = rd_idx_q;
  assign rd_wdata_o = rd_wdata_q;
  assign gnt_id_o   = gnt_id_q;

`ifdef RF_WB_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_cnt_q,    stall_cnt_d;
  logic        multi_valid;
  logic        any_valid;

  assign multi_valid = ($countones(req_valid_i) >= 2);
  assign any_valid   = |req_valid_i;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (multi_valid && !stall_i && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
    if (stall_i && any_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Self-checking bench for rf_wb_arbiter with NREQ=3 and 32-bit data.
// A table of directed cycles covers single-source writes, round-robin order,
// x0 writes, stalls and back-to-back grants; hand-written cycles cover reset
// in mid-stream and the optional performance counters; a randomized phase
// compares against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif

module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XL   = `XLEN;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*5-1:0]  req_idx_i;
  logic [NREQ*XL-1:0] req_wdata_i;
  logic [NREQ-1:0]    req_ready_o;
  logic               stall_i;
  logic               rd_en_o;
  logic [4:0]         rd_idx_o;
  logic [XL-1:0]      rd_wdata_o;
  logic [1:0]         gnt_id_o;
`ifdef RF_WB_PERF_EN
  logic [31:0]        conflict_cnt_o;
  logic [31:0]        stall_cnt_o;
`endif

  rf_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_idx_i   (req_idx_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .stall_i     (stall_i),
    .rd_en_o     (rd_en_o),
    .rd_idx_o    (rd_idx_o),
    .rd_wdata_o  (rd_wdata_o),
    .gnt_id_o    (gnt_id_o)
`ifdef RF_WB_PERF_EN
    ,
    .conflict_cnt_o (conflict_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;

  // One directed cycle: inputs held for the cycle, the ready expected during
  // it, and the rd_* values expected right after the following clock edge.
  typedef struct {
    logic          rst;
    logic          st;
    logic [2:0]    valid;
    logic [14:0]   idx;
    logic [95:0]   data;
    logic [2:0]    eReady;
    logic          eEn;
    logic [4:0]    eIdx;
    logic [31:0]   eData;
    logic [1:0]    eGnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(input logic rst, input logic st, input logic [2:0] valid,
                                 input int i0, input int i1, input int i2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [2:0] eReady, input logic eEn, input int eIdx,
                                 input logic [31:0] eData, input int eGnt);
    vec_t v;
    v.rst    = rst;
    v.st     = st;
    v.valid  = valid;
    v.idx    = {5'(i2), 5'(i1), 5'(i0)};
    v.data   = {d2, d1, d0};
    v.eReady = eReady;
    v.eEn    = eEn;
    v.eIdx   = 5'(eIdx);
    v.eData  = eData;
    v.eGnt   = 2'(eGnt);
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs shortly after the falling edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic [2:0] valid,
                               input logic [14:0] idx, input logic [95:0] data);
    reset       = rst;
    stall_i     = st;
    req_valid_i = valid;
    req_idx_i   = idx;
    req_wdata_i = data;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eEn, input logic [4:0] eIdx,
                             input logic [31:0] eData, input logic [1:0] eGnt);
    checkVal({name, ".rd"}, 64'({rd_en_o, rd_idx_o, rd_wdata_o, gnt_id_o}),
             64'({eEn, eIdx, eData, eGnt}));
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v.rst, v.st, v.valid, v.idx, v.data);
    checkVal({name, ".ready"}, 64'(req_ready_o), 64'(v.eReady));
    @(posedge clk);
    #1;
    checkOutput(name, v.eEn, v.eIdx, v.eData, v.eGnt);
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model for the random phase
  // -------------------------------------------------------------------------
  int          mPtr;
  logic        mEn;
  logic [4:0]  mIdx;
  logic [31:0] mData;
  int          mGnt;

  function automatic int modelWinner(input logic [2:0] v, input logic st, input logic rs);
    if (rs || st) return -1;
    for (int off = 0; off < NREQ; off++) begin
      int s;
      s = (mPtr + off) % NREQ;
      if (v[s]) return s;
    end
    return -1;
  endfunction

  logic        pv[NREQ];
  logic [4:0]  pidx[NREQ];
  logic [31:0] pdat[NREQ];
  int          age[NREQ];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    stall_i     = 1'b0;
    req_valid_i = '0;
    req_idx_i   = '0;
    req_wdata_i = '0;
    @(negedge clk);

    // Reset state, with every source requesting: nothing may be accepted.
    runVec("reset0", mkVec(1, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b000, 0, 0, 32'h0, 0));
    runVec("reset1", mkVec(1, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b000, 0, 0, 32'h0, 0));

    // Single source write, then hold with nothing requesting.
    tbl.push_back(mkVec(0, 0, 3'b010, 0, 5, 0, 32'h0, 32'hDEAD_BEEF, 32'h0, 3'b010, 1, 5, 32'hDEAD_BEEF, 1));
    tbl.push_back(mkVec(0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 5, 32'hDEAD_BEEF, 1));
    tbl.push_back(mkVec(1, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0, 0));
    // Round-robin over three continuously valid sources.
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mkVec(0, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 1, 1, 32'h11, 0));
      tbl.push_back(mkVec(0, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b010, 1, 2, 32'h22, 1));
      tbl.push_back(mkVec(0, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b100, 1, 3, 32'h33, 2));
    end
    // x0 write from source 2 is consumed but not enabled; pointer wraps to 0.
    tbl.push_back(mkVec(0, 0, 3'b100, 0, 0, 0, 32'h0, 32'h0, 32'h1234, 3'b100, 0, 0, 32'h1234, 2));
    tbl.push_back(mkVec(0, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 1, 1, 32'h11, 0));
    // Park the pointer at 0, then stall with sources 0 and 2 pending.
    tbl.push_back(mkVec(0, 0, 3'b100, 0, 0, 3, 32'h0, 32'h0, 32'h33, 3'b100, 1, 3, 32'h33, 2));
    for (int r = 0; r < 3; r++) begin
      tbl.push_back(mkVec(0, 1, 3'b101, 1, 0, 3, 32'h11, 32'h0, 32'h33, 3'b000, 0, 3, 32'h33, 2));
    end
    tbl.push_back(mkVec(0, 0, 3'b101, 1, 0, 3, 32'h11, 32'h0, 32'h33, 3'b001, 1, 1, 32'h11, 0));
    tbl.push_back(mkVec(0, 0, 3'b101, 1, 0, 3, 32'h11, 32'h0, 32'h33, 3'b100, 1, 3, 32'h33, 2));
    tbl.push_back(mkVec(0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 3, 32'h33, 2));
    // Back-to-back grants to the only valid source.
    tbl.push_back(mkVec(0, 0, 3'b010, 0, 7, 0, 32'h0, 32'h77, 32'h0, 3'b010, 1, 7, 32'h77, 1));
    tbl.push_back(mkVec(0, 0, 3'b010, 0, 8, 0, 32'h0, 32'h88, 32'h0, 3'b010, 1, 8, 32'h88, 1));
    tbl.push_back(mkVec(0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 8, 32'h88, 1));

    foreach (tbl[k]) begin
      runVec($sformatf("row%0d", k), tbl[k]);
    end

    // Reset in the cycle after a transfer: the write vanishes and the
    // pointer (which would be at 2) restarts at 0.
    runVec("rstmid.xfer", mkVec(0, 0, 3'b010, 0, 9, 0, 32'h0, 32'h99, 32'h0, 3'b010, 1, 9, 32'h99, 1));
    runVec("rstmid.rst",  mkVec(1, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b000, 0, 0, 32'h0, 0));
    runVec("rstmid.post", mkVec(0, 0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 1, 1, 32'h11, 0));

    // Randomized phase against the model; the first cycle resets both.
    for (int s = 0; s < NREQ; s++) begin
      pv[s] = 1'b0; pidx[s] = '0; pdat[s] = '0; age[s] = 0;
    end
    mPtr = 0; mEn = 0; mIdx = 0; mData = 0; mGnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        rs, st;
      logic [2:0]  v;
      logic [14:0] iv;
      logic [95:0] dv;
      int          w;
      for (int s = 0; s < NREQ; s++) begin
        if (!pv[s] && ($urandom_range(0, 2) == 0)) begin
          pv[s]   = 1'b1;
          pidx[s] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pdat[s] = $urandom;
        end
      end
      rs = (cyc == 0) || ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 4) == 0);
      v  = {pv[2], pv[1], pv[0]};
      iv = {pidx[2], pidx[1], pidx[0]};
      dv = {pdat[2], pdat[1], pdat[0]};
      w  = modelWinner(v, st, rs);
      applyStimulus(rs, st, v, iv, dv);
      checkVal($sformatf("rand%0d.ready", cyc), 64'(req_ready_o),
               64'((w >= 0) ? (3'b001 << w) : 3'b000));
      @(posedge clk);
      #1;
      if (rs) begin
        mEn = 0; mIdx = 0; mData = 0; mGnt = 0; mPtr = 0;
        for (int s = 0; s < NREQ; s++) age[s] = 0;
      end else if (w >= 0) begin
        mEn   = (pidx[w] != 5'd0);
        mIdx  = pidx[w];
        mData = pdat[w];
        mGnt  = w;
        mPtr  = (w + 1) % NREQ;
        checkVal($sformatf("rand%0d.fair", cyc), 64'(age[w] <= NREQ - 1), 64'(1));
        for (int s = 0; s < NREQ; s++) begin
          if (s != w && pv[s]) age[s]++;
        end
        age[w] = 0;
        pv[w]  = 1'b0;
      end else begin
        mEn = 0;
      end
      checkOutput($sformatf("rand%0d", cyc), mEn, mIdx, mData, 2'(mGnt));
      @(negedge clk);
    end

`ifdef RF_WB_PERF_EN
    // Counters: 4 unstalled conflict cycles, then 2 stalled pending cycles.
    runVec("perf.rst", mkVec(1, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0, 0));
    checkVal("perf.conflict0", 64'(conflict_cnt_o), 64'(0));
    checkVal("perf.stall0", 64'(stall_cnt_o), 64'(0));
    for (int r = 0; r < 2; r++) begin
      runVec("perf.c0", mkVec(0, 0, 3'b011, 1, 2, 0, 32'h11, 32'h22, 32'h0, 3'b001, 1, 1, 32'h11, 0));
      runVec("perf.c1", mkVec(0, 0, 3'b011, 1, 2, 0, 32'h11, 32'h22, 32'h0, 3'b010, 1, 2, 32'h22, 1));
    end
    for (int r = 0; r < 2; r++) begin
      runVec("perf.st", mkVec(0, 1, 3'b011, 1, 2, 0, 32'h11, 32'h22, 32'h0, 3'b000, 0, 2, 32'h22, 1));
    end
    checkVal("perf.conflict", 64'(conflict_cnt_o), 64'(4));
    checkVal("perf.stall", 64'(stall_cnt_o), 64'(2));
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (rd_en/rd_idx/rd_wdata) between NREQ writeback sources, e.g. ALU, LSU load return and CSR/MUL-DIV.
- Uses round-robin arbitration with a valid/ready handshake per source.
- Registers the winning write, so the register file sees a clean one-cycle-late write pulse.
- Sits between the writeback sources and the register file; the regfile is unchanged.

Parameters:
- NREQ, 3, number of requesters; legal range 2..4.
- Data width is `XLEN from defines.v, not a parameter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  NREQ  per-source write request valid
- req_idx_i  in  NREQ*5  per-source destination register index; source i at bits [5i+4:5i]
- req_wdata_i  in  NREQ*`XLEN  per-source write data; source i at slice i
- req_ready_o  out  NREQ  per-source accept; one-hot or zero
- stall_i  in  1  blocks all acceptance this cycle
- rd_en_o  out  1  write enable to register file
- rd_idx_o  out  5  write index to register file
- rd_wdata_o  out  `XLEN  write data to register file
- gnt_id_o  out  2  source number of the write currently on rd_*

Behaviour:
- Reset is synchronous, active-high, on clk:
  - rd_en_o=0, rd_idx_o=0, rd_wdata_o=0, gnt_id_o=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready_o is combinational; it is 0 while reset is high.
- Arbitration is combinational within one cycle:
  - Search sources starting at rr_ptr, ascending, wrapping modulo NREQ.
  - The first source with req_valid_i=1 is the winner, and its req_ready_o bit is 1.
  - If stall_i=1, or no source is valid, or reset=1, then req_ready_o=0.
- Transfer on source i occurs when req_valid_i[i] & req_ready_o[i] at a clk edge.
- Output stage, registered with 1-cycle latency:
  - On a transfer: rd_idx_o<=idx, rd_wdata_o<=data, gnt_id_o<=i, and rd_en_o<=(idx!=0).
  - A write to x0 is accepted (ready=1, so the source is consumed) but produces rd_en_o=0.
  - With no transfer: rd_en_o<=0; rd_idx_o, rd_wdata_o and gnt_id_o hold their previous values.
- Pointer update: after a transfer by source i, rr_ptr<=(i+1) mod NREQ. With no transfer, rr_ptr holds.
- Fairness: a continuously valid source is granted within NREQ cycles of becoming valid, provided stall_i is low.
- Sources must hold valid, idx and data stable until accepted. The arbiter never drops a request that has not been accepted.
- Throughput is at most one write per cycle, with back-to-back grants allowed, including to the same source when it is the only one valid.
- When stall_i is high, the output stage produces rd_en_o=0 the next cycle. Pending requests stay pending and rr_ptr is unchanged.
- Reset mid-operation: any pending write in the output stage is discarded (rd_en_o=0 the cycle after reset). Un-accepted requests are not granted while reset is high.
- Two sources targeting the same rd in successive cycles are written in grant order; the later write wins in the register file.

Optional Feature:
- Macro RF_WB_PERF_EN.
- Defined:
  - Adds output conflict_cnt_o [31:0], reset to 0.
  - Increments by 1 each cycle in which two or more req_valid_i bits are high and stall_i=0.
  - Saturates at 32'hFFFF_FFFF.
  - Also adds output stall_cnt_o [31:0]: counts cycles with stall_i=1 and any req_valid_i high; same reset and saturation rules.
- Not defined: neither port nor its counter logic exists; all other behaviour is identical.

Test Plan:
- Single source: source 1 presents idx=5, data=32'hDEAD_BEEF -> ready[1]=1 that cycle; next cycle rd_en_o=1, rd_idx_o=5, rd_wdata_o=32'hDEAD_BEEF, gnt_id_o=1; following cycle rd_en_o=0.
- Round-robin: sources 0, 1 and 2 all continuously valid with idx 1, 2, 3 after reset -> grants 0,1,2,0,1,2 on consecutive cycles; rd_idx_o sequence 1,2,3,1,2,3 one cycle later.
- x0 write: source 2 presents idx=0, data=32'h1234 -> ready[2]=1; next cycle rd_en_o=0; rr_ptr advances to 0.
- Stall: sources 0 and 2 valid, stall_i=1 for 3 cycles -> ready=0 and rd_en_o=0 throughout; at stall release, source 0 is granted first (rr_ptr=0 retained).
- Reset mid-stream: assert reset in the cycle after a transfer -> rd_en_o=0 the next cycle; rr_ptr=0 and source 0 wins first after reset deasserts.
- RF_WB_PERF_EN: sources 0 and 1 valid for 4 cycles with no stall -> conflict_cnt_o=4; add 2 stall cycles with a request pending -> stall_cnt_o=2.
